// File: rtl/hb_decim2_pkg.sv
// Shared constants, coefficient table and FSM encoding for the half-band
// decimate-by-2 filter.
package hb_decim2_pkg;

    localparam int NTAPS  = 11;
    localparam int COEF_W = 10;
    localparam int ACC_W  = 28;
    localparam int SHIFT  = 7;
    localparam int TAP_W  = 4;

    // Half-band taps, DC gain 512 (= 2^(SHIFT+2)); odd taps other than the
    // centre are zero but still take a MAC cycle to keep the schedule fixed.
    localparam logic signed [COEF_W-1:0] COEFS [NTAPS] = '{
        10'sd3, 10'sd0, -10'sd25, 10'sd0, 10'sd150, 10'sd256,
        10'sd150, 10'sd0, -10'sd25, 10'sd0, 10'sd3
    };

    // Half-LSB bias applied before the arithmetic shift (round half up).
    localparam logic signed [ACC_W-1:0] RND_BIAS = ACC_W'(1 << (SHIFT - 1));

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_ROUND = 2'd2
    } state_t;

endpackage

// File: rtl/hb_decim2_if.sv
// Sample-stream bundle between the CIC3 stage, the half-band decimator and
// its consumer.
interface hb_decim2_if #(
    parameter int DIN_W  = 14,
    parameter int DOUT_W = 16
);

    logic        [DIN_W-1:0]  in_data;
    logic                     in_valid;
    logic signed [DOUT_W-1:0] out_data;
    logic                     out_valid;
    logic                     busy;
    logic                     ovf;

    modport master (
        output in_data,
        output in_valid,
        input  out_data,
        input  out_valid,
        input  busy,
        input  ovf
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output out_data,
        output out_valid,
        output busy,
        output ovf
    );

endinterface

// File: rtl/hb_decim2_mac.sv
// Single multiplier-accumulator: one tap product added per enabled cycle.
module hb_decim2_mac
    import hb_decim2_pkg::*;
#(
    parameter int DIN_W = 14
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DIN_W-1:0]  sample,
    input  logic signed [COEF_W-1:0] coef,
    output logic signed [ACC_W-1:0]  acc_p1
);

    logic signed [DIN_W+COEF_W-1:0] prod_p0;
    logic signed [ACC_W-1:0]        prod_ext_p0;

    assign prod_p0     = sample * coef;
    assign prod_ext_p0 = ACC_W'(prod_p0);

    // Accumulator: cleared when a computation starts, then one product per MAC cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_p1 <= '0;
        end else if (clr) begin
            acc_p1 <= '0;
        end else if (en) begin
            acc_p1 <= acc_p1 + prod_ext_p0;
        end
    end

endmodule

// File: rtl/hb_decim2.sv
// Half-band FIR decimate-by-2 for the CIC3 output stream. Samples are
// offset-binary in, two's complement out. One output is computed for every
// second accepted sample, sequentially over 11 MAC cycles plus one rounding
// cycle. A single holding register absorbs one sample arriving while busy.
module hb_decim2
    import hb_decim2_pkg::*;
#(
    parameter int DIN_W  = 14,
    parameter int DOUT_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    hb_decim2_if.slave  bus
);

    state_t                    state, state_nxt;
    logic        [TAP_W-1:0]   tap_idx;
    logic signed [DIN_W-1:0]   dline [NTAPS];
    logic                      phase;
    logic                      hold_vld;
    logic        [DIN_W-1:0]   hold_data;
    logic                      ovf_q;
    logic                      accept;
    logic        [DIN_W-1:0]   accept_raw;
    logic                      trigger;
    logic                      mac_clr;
    logic                      mac_en;
    logic                      round_en;
    logic signed [ACC_W-1:0]   acc_p1;
    logic signed [DOUT_W-1:0]  out_data_p2;
    logic                      out_vld_p2;

    // Offset binary to two's complement: flip the MSB.
    function automatic logic signed [DIN_W-1:0] to_signed(input logic [DIN_W-1:0] d);
        return {~d[DIN_W-1], d[DIN_W-2:0]};
    endfunction

    // (acc + half LSB) >>> SHIFT; dropping the low bits of a signed value is
    // the arithmetic shift, so only the upper slice is kept.
    function automatic logic signed [ACC_W-SHIFT-1:0] round_shift(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] biased;
        biased = a + RND_BIAS;
        return biased[ACC_W-1:SHIFT];
    endfunction

    // Clamp the rounded value into the DOUT_W signed range.
    function automatic logic signed [DOUT_W-1:0] saturate(input logic signed [ACC_W-SHIFT-1:0] v);
        logic signed [ACC_W-SHIFT-1:0] vmax;
        logic signed [ACC_W-SHIFT-1:0] vmin;
        vmax = (ACC_W-SHIFT)'({1'b0, {(DOUT_W-1){1'b1}}});
        vmin = ~vmax;
        if (v > vmax) begin
            return vmax[DOUT_W-1:0];
        end else if (v < vmin) begin
            return vmin[DOUT_W-1:0];
        end else begin
            return v[DOUT_W-1:0];
        end
    endfunction

    // Accept only in IDLE; a held sample always goes before a new strobe.
    always_comb begin
        accept     = 1'b0;
        accept_raw = bus.in_data;
        if (state == ST_IDLE) begin
            if (hold_vld) begin
                accept     = 1'b1;
                accept_raw = hold_data;
            end else if (bus.in_valid) begin
                accept = 1'b1;
            end
        end
    end

    assign trigger = accept & phase;

    // Holding register and sticky overrun flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_vld  <= 1'b0;
            hold_data <= '0;
            ovf_q     <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (hold_vld) begin
                hold_vld <= bus.in_valid;
                if (bus.in_valid) begin
                    hold_data <= bus.in_data;
                end
            end
        end else if (bus.in_valid) begin
            if (!hold_vld) begin
                hold_vld  <= 1'b1;
                hold_data <= bus.in_data;
            end else begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Delay line and decimation phase advance only on an accepted sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase <= 1'b0;
            for (int i = 0; i < NTAPS; i++) begin
                dline[i] <= '0;
            end
        end else if (accept) begin
            phase    <= ~phase;
            dline[0] <= to_signed(accept_raw);
            for (int i = NTAPS - 1; i > 0; i--) begin
                dline[i] <= dline[i-1];
            end
        end
    end

    // FSM state and tap counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            tap_idx <= '0;
        end else begin
            state <= state_nxt;
            if (mac_clr) begin
                tap_idx <= '0;
            end else if (mac_en) begin
                tap_idx <= tap_idx + 1'b1;
            end
        end
    end

    // FSM next state and datapath controls.
    always_comb begin
        state_nxt = state;
        mac_clr   = 1'b0;
        mac_en    = 1'b0;
        round_en  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (trigger) begin
                    state_nxt = ST_MAC;
                    mac_clr   = 1'b1;
                end
            end
            ST_MAC: begin
                mac_en = 1'b1;
                if (tap_idx == TAP_W'(NTAPS - 1)) begin
                    state_nxt = ST_ROUND;
                end
            end
            ST_ROUND: begin
                round_en  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    hb_decim2_mac #(
        .DIN_W (DIN_W)
    ) u_mac (
        .clk    (clk),
        .reset  (reset),
        .clr    (mac_clr),
        .en     (mac_en),
        .sample (dline[tap_idx]),
        .coef   (COEFS[tap_idx]),
        .acc_p1 (acc_p1)
    );

    // Output register: rounded, saturated result with a one-cycle valid strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_p2 <= '0;
            out_vld_p2  <= 1'b0;
        end else begin
            out_vld_p2 <= round_en;
            if (round_en) begin
                out_data_p2 <= saturate(round_shift(acc_p1));
            end
        end
    end

    assign bus.out_data  = out_data_p2;
    assign bus.out_valid = out_vld_p2;
    assign bus.busy      = (state != ST_IDLE);
    assign bus.ovf       = ovf_q;

endmodule
